// File: rtl/uart_core_fifo_if.sv
// CPU-side register bus of uart_core_fifo: TX queueing, RX popping,
// FIFO status and sticky receive error flags.
interface uart_core_fifo_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              data_write_en;
    logic              tx_ready;
    logic              tx_busy;
    logic [DATA_W-1:0] rx_data;
    logic              data_read_en;
    logic              rx_ready;
    logic              rx_parity_err;
    logic              rx_frame_err;
    logic              rx_overrun;

    modport master (
        output tx_data, data_write_en, data_read_en,
        input  tx_ready, tx_busy, rx_data, rx_ready,
        input  rx_parity_err, rx_frame_err, rx_overrun
    );

    modport slave (
        input  tx_data, data_write_en, data_read_en,
        output tx_ready, tx_busy, rx_data, rx_ready,
        output rx_parity_err, rx_frame_err, rx_overrun
    );
endinterface

// File: rtl/uart_core_fifo.sv
// Parametrised UART with TX/RX FIFOs, runtime parity/stop selection,
// sticky RX error flags and RTS/CTS flow control tied to RX occupancy.
module uart_core_fifo #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16,
    parameter int TX_AW  = 2,
    parameter int RX_AW  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rst_soft,
    input  logic             tx_en,
    input  logic             rx_en,
    input  logic [DIV_W-1:0] bit_duration,
    input  logic [1:0]       parity_mode,
    input  logic             stop2,
    uart_core_fifo_if.slave  bus,
    output logic             txd,
    input  logic             rxd,
    output logic             rts,
    input  logic             cts
);
    localparam int TX_D = 1 << TX_AW;
    localparam int RX_D = 1 << RX_AW;
    localparam int BW   = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);
    localparam logic [RX_AW:0] RTS_MAX = (RX_AW + 1)'(RX_D - 2);

    typedef enum logic [2:0] {
        T_IDLE, T_START, T_DATA, T_PARITY, T_STOP1, T_STOP2
    } tx_state_t;

    typedef enum logic [2:0] {
        R_IDLE, R_START, R_DATA, R_PARITY, R_STOP, R_WAIT
    } rx_state_t;

    // ---------------- TX FIFO ----------------
    logic [DATA_W-1:0] tx_mem [TX_D];
    logic [TX_AW:0]    tx_wr, tx_rd;
    logic              tx_empty, tx_full, tx_push, tx_start;
    logic [DATA_W-1:0] tx_head;

    assign tx_empty = tx_wr == tx_rd;
    assign tx_full  = (tx_wr[TX_AW] != tx_rd[TX_AW]) &&
                      (tx_wr[TX_AW-1:0] == tx_rd[TX_AW-1:0]);
    assign tx_push  = bus.data_write_en && !tx_full;
    assign tx_head  = tx_mem[tx_rd[TX_AW-1:0]];
    assign bus.tx_ready = tx_en && !tx_full;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr[TX_AW-1:0]] <= bus.tx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr <= '0;
            tx_rd <= '0;
        end else if (rst_soft) begin
            tx_wr <= '0;
            tx_rd <= '0;
        end else begin
            if (tx_push)  tx_wr <= tx_wr + 1'b1;
            if (tx_start) tx_rd <= tx_rd + 1'b1;
        end
    end

    // ---------------- TX FSM ----------------
    tx_state_t         tx_state;
    logic [DIV_W-1:0]  tx_cnt, tx_div;
    logic [BW-1:0]     tx_bit;
    logic [DATA_W-1:0] tx_sh;
    logic              tx_par, tx_pen, tx_st2;
    logic              tx_tick, tx_last;

    assign tx_tick  = tx_cnt == tx_div - 1'b1;
    assign tx_last  = tx_tick && ((tx_state == T_STOP1 && !tx_st2) ||
                                  tx_state == T_STOP2);
    // A new frame may start straight out of the last stop bit.
    assign tx_start = tx_en && cts && !tx_empty &&
                      (tx_state == T_IDLE || tx_last);
    assign bus.tx_busy = (tx_state != T_IDLE) || !tx_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= T_IDLE;
            tx_cnt   <= '0;
            tx_div   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
            tx_pen   <= 1'b0;
            tx_st2   <= 1'b0;
            txd      <= 1'b1;
        end else if (rst_soft) begin
            tx_state <= T_IDLE;
            tx_cnt   <= '0;
            tx_div   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
            tx_pen   <= 1'b0;
            tx_st2   <= 1'b0;
            txd      <= 1'b1;
        end else if (tx_start) begin
            tx_state <= T_START;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= tx_head;
            tx_div   <= bit_duration;
            tx_pen   <= parity_mode[0] ^ parity_mode[1];
            tx_par   <= (^tx_head) ^ parity_mode[1];
            tx_st2   <= stop2;
            txd      <= 1'b0;
        end else if (tx_state != T_IDLE) begin
            if (!tx_tick) begin
                tx_cnt <= tx_cnt + 1'b1;
            end else begin
                tx_cnt <= '0;
                unique case (tx_state)
                    T_START: begin
                        tx_state <= T_DATA;
                        txd      <= tx_sh[0];
                    end
                    T_DATA: begin
                        if (tx_bit == LAST) begin
                            tx_state <= tx_pen ? T_PARITY : T_STOP1;
                            txd      <= tx_pen ? tx_par : 1'b1;
                        end else begin
                            tx_bit <= tx_bit + 1'b1;
                            tx_sh  <= tx_sh >> 1;
                            txd    <= tx_sh[1];
                        end
                    end
                    T_PARITY: begin
                        tx_state <= T_STOP1;
                        txd      <= 1'b1;
                    end
                    T_STOP1: tx_state <= tx_st2 ? T_STOP2 : T_IDLE;
                    T_STOP2: tx_state <= T_IDLE;
                    default: tx_state <= T_IDLE;
                endcase
            end
        end
    end

    // ---------------- RX synchroniser ----------------
    logic rx_s1, rx_s2, rx_prev, rx_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else if (rst_soft) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall = rx_prev && !rx_s2;

    // ---------------- RX FSM ----------------
    rx_state_t         rx_state;
    logic [DIV_W-1:0]  rx_cnt, rx_div;
    logic [BW-1:0]     rx_bit;
    logic [DATA_W-1:0] rx_sh;
    logic              rx_pen, rx_odd;
    logic              rx_tick, rx_half, rx_push;
    logic              parity_err, frame_err;

    assign rx_tick = rx_cnt == rx_div - 1'b1;
    assign rx_half = rx_cnt == (rx_div >> 1) - 1'b1;
    assign rx_push = (rx_state == R_STOP) && rx_tick && rx_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state   <= R_IDLE;
            rx_cnt     <= '0;
            rx_div     <= '0;
            rx_bit     <= '0;
            rx_sh      <= '0;
            rx_pen     <= 1'b0;
            rx_odd     <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else if (rst_soft) begin
            rx_state   <= R_IDLE;
            rx_cnt     <= '0;
            rx_div     <= '0;
            rx_bit     <= '0;
            rx_sh      <= '0;
            rx_pen     <= 1'b0;
            rx_odd     <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            unique case (rx_state)
                R_IDLE: begin
                    if (rx_en && rx_fall) begin
                        rx_state <= R_START;
                        rx_cnt   <= '0;
                        rx_div   <= bit_duration;
                        rx_pen   <= parity_mode[0] ^ parity_mode[1];
                        rx_odd   <= parity_mode[1];
                    end
                end
                R_START: begin
                    if (rx_half) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s2 ? R_IDLE : R_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (rx_tick) begin
                        rx_cnt <= '0;
                        rx_sh  <= {rx_s2, rx_sh[DATA_W-1:1]};
                        if (rx_bit == LAST)
                            rx_state <= rx_pen ? R_PARITY : R_STOP;
                        else
                            rx_bit <= rx_bit + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                R_PARITY: begin
                    if (rx_tick) begin
                        rx_cnt   <= '0;
                        rx_state <= R_STOP;
                        if (rx_s2 != ((^rx_sh) ^ rx_odd)) parity_err <= 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (rx_tick) begin
                        rx_cnt <= '0;
                        if (!rx_s2) begin
                            frame_err <= 1'b1;
                            rx_state  <= R_WAIT;
                        end else begin
                            rx_state <= R_IDLE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                R_WAIT: if (rx_s2) rx_state <= R_IDLE;
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_W-1:0] rx_mem [RX_D];
    logic [RX_AW:0]    rx_wr, rx_rd, rx_level;
    logic              rx_empty, rx_full, rx_pop, rx_wr_ok, overrun;

    assign rx_empty = rx_wr == rx_rd;
    assign rx_full  = (rx_wr[RX_AW] != rx_rd[RX_AW]) &&
                      (rx_wr[RX_AW-1:0] == rx_rd[RX_AW-1:0]);
    assign rx_level = rx_wr - rx_rd;
    assign rx_pop   = bus.data_read_en && !rx_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign rx_wr_ok = rx_push && (!rx_full || rx_pop);

    always_ff @(posedge clk) begin
        if (rx_wr_ok) rx_mem[rx_wr[RX_AW-1:0]] <= rx_sh;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr   <= '0;
            rx_rd   <= '0;
            overrun <= 1'b0;
            rts     <= 1'b0;
        end else if (rst_soft) begin
            rx_wr   <= '0;
            rx_rd   <= '0;
            overrun <= 1'b0;
            rts     <= 1'b0;
        end else begin
            if (rx_wr_ok) rx_wr <= rx_wr + 1'b1;
            if (rx_pop)   rx_rd <= rx_rd + 1'b1;
            if (rx_push && !rx_wr_ok) overrun <= 1'b1;
            rts <= rx_en && (rx_level <= RTS_MAX);
        end
    end

    assign bus.rx_ready      = !rx_empty;
    assign bus.rx_data       = rx_empty ? '0 : rx_mem[rx_rd[RX_AW-1:0]];
    assign bus.rx_parity_err = parity_err;
    assign bus.rx_frame_err  = frame_err;
    assign bus.rx_overrun    = overrun;
endmodule
